ahb3lite_arbiter: RTL and testbench

Round-robin bus arbiter that shares one AHB-Lite slave-side bus between `NUM_MASTERS` requesting masters. It monitors the muxed bus `HTRANS`/`HBURST`/`HREADY` and moves ownership only at legal transfer boundaries: IDLE cycles, the last beat of a fixed-length burst, or when an INCR owner drops its request. It outputs a registered one-hot grant plus the address-phase and data-phase owner indices that drive the external address/control and write-data/response multiplexers.

---
 rtl/ahb3lite_arbiter.sv | 137 +++++++++++++
 tb/tb_ahb3lite_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : ahb3lite_arbiter
// Brief    : Round-robin AHB-Lite bus arbiter. It hands over ownership only at
//            legal transfer boundaries. Define AHB3LITE_ARB_FIXED_PRIO_EN to
//            select fixed (lowest index wins) priority instead.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module ahb3lite_arbiter #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       addr_owner,
    output logic [IDX_W-1:0]       data_owner
);

    localparam logic [1:0] c_trans_idle   = 2'd0;
    localparam logic [1:0] c_trans_busy   = 2'd1;
    localparam logic [1:0] c_trans_nonseq = 2'd2;
    localparam logic [1:0] c_trans_seq    = 2'd3;

    localparam logic [2:0] c_burst_single = 3'd0;
    localparam logic [2:0] c_burst_incr   = 3'd1;
    localparam logic [2:0] c_burst_wrap4  = 3'd2;
    localparam logic [2:0] c_burst_incr4  = 3'd3;
    localparam logic [2:0] c_burst_wrap8  = 3'd4;
    localparam logic [2:0] c_burst_incr8  = 3'd5;
    localparam logic [2:0] c_burst_wrap16 = 3'd6;
    localparam logic [2:0] c_burst_incr16 = 3'd7;

    logic [NUM_MASTERS-1:0] r_grant;
    logic [IDX_W-1:0]       r_addr_owner;
    logic [IDX_W-1:0]       r_data_owner;
    logic [4:0]             r_beats_left;
`ifndef AHB3LITE_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]       r_rr_ptr;
`endif

    logic [4:0]             w_beats_next;
    logic                   w_is_incr;
    logic                   w_hp;
    logic [IDX_W-1:0]       w_cand;
    logic [IDX_W-1:0]       w_winner;
    logic                   w_found;

    // Beats remaining after the one just accepted, for fixed-length bursts.
    function automatic logic [4:0] burst_last(input logic [2:0] burst);
        case (burst)
            c_burst_wrap4,  c_burst_incr4:  return 5'd3;
            c_burst_wrap8,  c_burst_incr8:  return 5'd7;
            c_burst_wrap16, c_burst_incr16: return 5'd15;
            default:                        return 5'd0;
        endcase
    endfunction

    always_comb begin
        w_beats_next = r_beats_left;
        if (HREADY) begin
            case (HTRANS)
                c_trans_nonseq: w_beats_next = burst_last(HBURST);
                c_trans_seq:    w_beats_next = (r_beats_left == 5'd0) ? 5'd0
                                                                      : r_beats_left - 5'd1;
                c_trans_idle:   w_beats_next = 5'd0;
                c_trans_busy:   w_beats_next = r_beats_left;
                default:        w_beats_next = r_beats_left;
            endcase
        end
    end

    assign w_is_incr = (HBURST == c_burst_incr);

    // An undefined-length burst may be broken as soon as its owner lets go.
    always_comb begin
        w_hp = 1'b0;
        if (HREADY && (HTRANS != c_trans_busy)) begin
            w_hp = (HTRANS == c_trans_idle)
                || ((HTRANS == c_trans_nonseq) && (HBURST == c_burst_single))
                || ((HTRANS == c_trans_seq) && (r_beats_left == 5'd1) && !w_is_incr)
                || (w_is_incr && HTRANS[1] && !req[r_addr_owner]);
        end
    end

    // The owner is visited last, so it keeps the bus only when nobody else asks.
    always_comb begin
        w_cand   = '0;
        w_winner = r_addr_owner;
        w_found  = 1'b0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
`ifdef AHB3LITE_ARB_FIXED_PRIO_EN
            w_cand = IDX_W'(i - 1);
`else
            w_cand = IDX_W'((int'(r_rr_ptr) + i) % NUM_MASTERS);
`endif
            if (!w_found && req[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_grant      <= NUM_MASTERS'(1);
            r_addr_owner <= '0;
            r_data_owner <= '0;
            r_beats_left <= 5'd0;
`ifndef AHB3LITE_ARB_FIXED_PRIO_EN
            r_rr_ptr     <= '0;
`endif
        end else begin
            r_beats_left <= w_beats_next;
            if (HREADY) begin
                r_data_owner <= r_addr_owner;
            end
            if (w_hp) begin
                r_addr_owner <= w_winner;
                r_grant      <= NUM_MASTERS'(1) << w_winner;
`ifndef AHB3LITE_ARB_FIXED_PRIO_EN
                r_rr_ptr     <= w_winner;
`endif
            end
        end
    end

    assign grant      = r_grant;
    assign addr_owner = r_addr_owner;
    assign data_owner = r_data_owner;

endmodule
`default_nettype wire

// File: tb/tb_ahb3lite_arbiter.sv
`default_nettype none
// Testbench for ahb3lite_arbiter: table-driven vectors checked through a
// scoreboard queue, plus short hand-written idle-bus sequences.
module tb_ahb3lite_arbiter;

    localparam logic [1:0] T_IDLE = 2'd0, T_BUSY = 2'd1, T_NSEQ = 2'd2, T_SEQ = 2'd3;
    localparam logic [2:0] B_SINGLE = 3'd0, B_INCR = 3'd1, B_INCR4 = 3'd3,
                           B_INCR8 = 3'd5, B_WRAP16 = 3'd6;

    logic       HCLK = 1'b0;
    logic       HRESETn;
    logic [3:0] req;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic       HREADY;
    logic [3:0] grant;
    logic [1:0] addr_owner;
    logic [1:0] data_owner;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [1:0] trans;
        logic [2:0] burst;
        logic       ready;
        logic [3:0] g;
        logic [1:0] ao;
        logic [1:0] dow;
        logic [4:0] bl;
    } vec_t;

    typedef struct {
        logic [3:0] g;
        logic [1:0] ao;
        logic [1:0] dow;
        logic [4:0] bl;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 HCLK = ~HCLK;

    ahb3lite_arbiter #(.NUM_MASTERS(4), .IDX_W(2)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .req       (req),
        .HTRANS    (HTRANS),
        .HBURST    (HBURST),
        .HREADY    (HREADY),
        .grant     (grant),
        .addr_owner(addr_owner),
        .data_owner(data_owner)
    );

    function automatic vec_t mk(input logic rst_n, input logic [3:0] rq,
                                input logic [1:0] tr, input logic [2:0] bu,
                                input logic rdy, input logic [3:0] g,
                                input logic [1:0] ao, input logic [1:0] dow,
                                input logic [4:0] bl);
        vec_t v;
        v.rst_n = rst_n; v.req = rq; v.trans = tr; v.burst = bu; v.ready = rdy;
        v.g = g; v.ao = ao; v.dow = dow; v.bl = bl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        exp_t e;
        HRESETn = v.rst_n; req = v.req; HTRANS = v.trans; HBURST = v.burst; HREADY = v.ready;
        e.g = v.g; e.ao = v.ao; e.dow = v.dow; e.bl = v.bl;
        sb.push_back(e);
        @(posedge HCLK);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard empty actual 0 required 1", tag);
        end else begin
            e = sb.pop_front();
            check({tag, ".grant"},      32'(grant),            32'(e.g));
            check({tag, ".addr_owner"}, 32'(addr_owner),       32'(e.ao));
            check({tag, ".data_owner"}, 32'(data_owner),       32'(e.dow));
            check({tag, ".beats_left"}, 32'(dut.r_beats_left), 32'(e.bl));
        end
    endtask

    initial begin
        HRESETn = 1'b0; req = 4'b0; HTRANS = T_IDLE; HBURST = B_SINGLE; HREADY = 1'b1;
        // reset held two cycles with everyone requesting
        vecs.push_back(mk(0, 4'b1111, T_IDLE, B_SINGLE, 1, 4'b0001, 0, 0, 0));
        vecs.push_back(mk(0, 4'b1111, T_IDLE, B_SINGLE, 1, 4'b0001, 0, 0, 0));
`ifndef AHB3LITE_ARB_FIXED_PRIO_EN
        // round robin with single transfers
        vecs.push_back(mk(1, 4'b1111, T_NSEQ, B_SINGLE, 1, 4'b0010, 1, 0, 0));
        vecs.push_back(mk(1, 4'b1111, T_NSEQ, B_SINGLE, 1, 4'b0100, 2, 1, 0));
        vecs.push_back(mk(1, 4'b1111, T_NSEQ, B_SINGLE, 1, 4'b1000, 3, 2, 0));
        vecs.push_back(mk(1, 4'b1111, T_NSEQ, B_SINGLE, 1, 4'b0001, 0, 3, 0));
        // INCR4 by m0 with wait states on beat 2, m1 waiting
        vecs.push_back(mk(1, 4'b0001, T_IDLE, B_SINGLE, 1, 4'b0001, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0011, T_NSEQ, B_INCR4,  1, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(1, 4'b0011, T_SEQ,  B_INCR4,  0, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(1, 4'b0011, T_SEQ,  B_INCR4,  0, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(1, 4'b0011, T_SEQ,  B_INCR4,  1, 4'b0001, 0, 0, 2));
        vecs.push_back(mk(1, 4'b0011, T_SEQ,  B_INCR4,  1, 4'b0001, 0, 0, 1));
        vecs.push_back(mk(1, 4'b0011, T_SEQ,  B_INCR4,  1, 4'b0010, 1, 0, 0));
        vecs.push_back(mk(1, 4'b0010, T_NSEQ, B_SINGLE, 0, 4'b0010, 1, 0, 0));
        vecs.push_back(mk(1, 4'b0010, T_NSEQ, B_SINGLE, 1, 4'b0010, 1, 1, 0));
        // INCR8 by m0 with two BUSY cycles after beat 3, m2 waiting
        vecs.push_back(mk(1, 4'b0001, T_IDLE, B_SINGLE, 1, 4'b0001, 0, 1, 0));
        vecs.push_back(mk(1, 4'b0101, T_NSEQ, B_INCR8,  1, 4'b0001, 0, 0, 7));
        vecs.push_back(mk(1, 4'b0101, T_SEQ,  B_INCR8,  1, 4'b0001, 0, 0, 6));
        vecs.push_back(mk(1, 4'b0101, T_SEQ,  B_INCR8,  1, 4'b0001, 0, 0, 5));
        vecs.push_back(mk(1, 4'b0101, T_BUSY, B_INCR8,  1, 4'b0001, 0, 0, 5));
        vecs.push_back(mk(1, 4'b0101, T_BUSY, B_INCR8,  1, 4'b0001, 0, 0, 5));
        vecs.push_back(mk(1, 4'b0101, T_SEQ,  B_INCR8,  1, 4'b0001, 0, 0, 4));
        vecs.push_back(mk(1, 4'b0101, T_SEQ,  B_INCR8,  1, 4'b0001, 0, 0, 3));
        vecs.push_back(mk(1, 4'b0101, T_SEQ,  B_INCR8,  1, 4'b0001, 0, 0, 2));
        vecs.push_back(mk(1, 4'b0101, T_SEQ,  B_INCR8,  1, 4'b0001, 0, 0, 1));
        vecs.push_back(mk(1, 4'b0101, T_SEQ,  B_INCR8,  1, 4'b0100, 2, 0, 0));
        // INCR by m1 released at beat 5, m3 waiting
        vecs.push_back(mk(1, 4'b0010, T_IDLE, B_SINGLE, 1, 4'b0010, 1, 2, 0));
        vecs.push_back(mk(1, 4'b1010, T_NSEQ, B_INCR,   1, 4'b0010, 1, 1, 0));
        vecs.push_back(mk(1, 4'b1010, T_SEQ,  B_INCR,   1, 4'b0010, 1, 1, 0));
        vecs.push_back(mk(1, 4'b1010, T_SEQ,  B_INCR,   1, 4'b0010, 1, 1, 0));
        vecs.push_back(mk(1, 4'b1010, T_SEQ,  B_INCR,   1, 4'b0010, 1, 1, 0));
        vecs.push_back(mk(1, 4'b1000, T_SEQ,  B_INCR,   1, 4'b1000, 3, 1, 0));
        // WRAP16 by m2, reset asserted on beat 7 while not ready
        vecs.push_back(mk(1, 4'b0100, T_IDLE, B_SINGLE, 1, 4'b0100, 2, 3, 0));
        vecs.push_back(mk(1, 4'b0101, T_NSEQ, B_WRAP16, 1, 4'b0100, 2, 2, 15));
        vecs.push_back(mk(1, 4'b0101, T_SEQ,  B_WRAP16, 1, 4'b0100, 2, 2, 14));
        vecs.push_back(mk(1, 4'b0101, T_SEQ,  B_WRAP16, 1, 4'b0100, 2, 2, 13));
        vecs.push_back(mk(1, 4'b0101, T_SEQ,  B_WRAP16, 1, 4'b0100, 2, 2, 12));
        vecs.push_back(mk(1, 4'b0101, T_SEQ,  B_WRAP16, 1, 4'b0100, 2, 2, 11));
        vecs.push_back(mk(1, 4'b0101, T_SEQ,  B_WRAP16, 1, 4'b0100, 2, 2, 10));
        vecs.push_back(mk(0, 4'b0101, T_SEQ,  B_WRAP16, 0, 4'b0001, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0000, T_IDLE, B_SINGLE, 1, 4'b0001, 0, 0, 0));
`else
        // fixed priority: m0 wins whenever it asks, even against the owner
        vecs.push_back(mk(1, 4'b0011, T_NSEQ, B_SINGLE, 1, 4'b0001, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0011, T_NSEQ, B_SINGLE, 1, 4'b0001, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0011, T_NSEQ, B_SINGLE, 1, 4'b0001, 0, 0, 0));
        vecs.push_back(mk(1, 4'b0010, T_NSEQ, B_SINGLE, 1, 4'b0010, 1, 0, 0));
        vecs.push_back(mk(1, 4'b0011, T_NSEQ, B_SINGLE, 1, 4'b0001, 0, 1, 0));
        vecs.push_back(mk(1, 4'b0011, T_NSEQ, B_SINGLE, 1, 4'b0001, 0, 0, 0));
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], $sformatf("v%0d", i));
        end

        // idle bus: a lone requester gets the grant one cycle after asking
        apply(mk(1, 4'b0100, T_IDLE, B_SINGLE, 1, 4'b0100, 2, 0, 0), "idle_switch");
        // nobody requesting: ownership parks on the current owner
        apply(mk(1, 4'b0000, T_IDLE, B_SINGLE, 1, 4'b0100, 2, 2, 0), "idle_park");
        // stalled bus: a new request must not move the grant
        apply(mk(1, 4'b1011, T_IDLE, B_SINGLE, 0, 4'b0100, 2, 2, 0), "stall_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
